// File: rtl/coproc_arbiter_if.sv
// Requester and coprocessor signal bundle for coproc_arbiter.
// The master modport is the environment side; the slave modport is the arbiter.
interface coproc_arbiter_if #(
    parameter int unsigned MAT_W = 200
);
    logic [1:0]       req;
    logic [2:0]       op0;
    logic [2:0]       op1;
    logic [1:0]       tam0;
    logic [1:0]       tam1;
    logic [MAT_W-1:0] a0;
    logic [MAT_W-1:0] b0;
    logic [MAT_W-1:0] a1;
    logic [MAT_W-1:0] b1;
    logic [1:0]       gnt;
    logic [1:0]       rsp_valid;
    logic [1:0]       rsp_ack;
    logic [MAT_W-1:0] result;
    logic             ovf;
    logic             timeout_err;
    logic             busy;
    logic             cp_start;
    logic [2:0]       cp_op;
    logic [1:0]       cp_tam;
    logic [MAT_W-1:0] cp_m1;
    logic [MAT_W-1:0] cp_m2;
    logic [MAT_W-1:0] cp_result;
    logic             cp_overflow;
    logic             cp_done;

    modport master (
        output req, op0, op1, tam0, tam1, a0, b0, a1, b1, rsp_ack,
        output cp_result, cp_overflow, cp_done,
        input  gnt, rsp_valid, result, ovf, timeout_err, busy,
        input  cp_start, cp_op, cp_tam, cp_m1, cp_m2
    );

    modport slave (
        input  req, op0, op1, tam0, tam1, a0, b0, a1, b1, rsp_ack,
        input  cp_result, cp_overflow, cp_done,
        output gnt, rsp_valid, result, ovf, timeout_err, busy,
        output cp_start, cp_op, cp_tam, cp_m1, cp_m2
    );
endinterface

// File: rtl/coproc_arbiter.sv
// Round-robin arbiter sharing one matrix coprocessor between two requesters,
// with a start/done sequencer, valid/ack response and a RUN-phase watchdog.
module coproc_arbiter #(
    parameter int unsigned MAT_W   = 200,
    parameter int unsigned TIMEOUT = 1023
) (
    input logic             clk,
    input logic             reset,
    coproc_arbiter_if.slave bus
);
    localparam int unsigned CntW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {StIdle, StDrain, StRun, StResp} state_e;

    state_e          state_q;
    logic            owner_q;
    logic            last_q;
    logic [CntW-1:0] cnt_q;
    logic            win;

    // A lone requester wins outright; on a tie the port that was not served last wins.
    always_comb begin
        win = bus.req[1];
        if (bus.req == 2'b11) begin
            win = ~last_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= StIdle;
            owner_q         <= 1'b0;
            last_q          <= 1'b1;
            cnt_q           <= '0;
            bus.gnt         <= '0;
            bus.rsp_valid   <= '0;
            bus.result      <= '0;
            bus.ovf         <= 1'b0;
            bus.timeout_err <= 1'b0;
            bus.busy        <= 1'b0;
            bus.cp_start    <= 1'b0;
            bus.cp_op       <= '0;
            bus.cp_tam      <= '0;
            bus.cp_m1       <= '0;
            bus.cp_m2       <= '0;
        end else begin
            bus.gnt <= '0;
            unique case (state_q)
                StIdle: begin
                    if (bus.req != 2'b00) begin
                        state_q  <= StDrain;
                        owner_q  <= win;
                        bus.gnt  <= win ? 2'b10 : 2'b01;
                        bus.busy <= 1'b1;
                        if (win) begin
                            bus.cp_op  <= bus.op1;
                            bus.cp_tam <= bus.tam1;
                            bus.cp_m1  <= bus.a1;
                            bus.cp_m2  <= bus.b1;
                        end else begin
                            bus.cp_op  <= bus.op0;
                            bus.cp_tam <= bus.tam0;
                            bus.cp_m1  <= bus.a0;
                            bus.cp_m2  <= bus.b0;
                        end
                    end
                end
                StDrain: begin
                    // A done left over from the previous job must fall before we start.
                    if (!bus.cp_done) begin
                        state_q      <= StRun;
                        bus.cp_start <= 1'b1;
                        cnt_q        <= '0;
                    end
                end
                StRun: begin
                    if (bus.cp_done) begin
                        state_q         <= StResp;
                        bus.result      <= bus.cp_result;
                        bus.ovf         <= bus.cp_overflow;
                        bus.timeout_err <= 1'b0;
                        bus.rsp_valid   <= owner_q ? 2'b10 : 2'b01;
                    end else if (cnt_q == CntW'(TIMEOUT)) begin
                        state_q         <= StResp;
                        bus.result      <= '0;
                        bus.ovf         <= 1'b0;
                        bus.timeout_err <= 1'b1;
                        bus.rsp_valid   <= owner_q ? 2'b10 : 2'b01;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StResp: begin
                    if (bus.rsp_ack[owner_q]) begin
                        state_q       <= StIdle;
                        bus.rsp_valid <= '0;
                        bus.cp_start  <= 1'b0;
                        bus.busy      <= 1'b0;
                        last_q        <= owner_q;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end
endmodule

// File: tb/tb_coproc_arbiter.sv
// Directed self-checking bench for coproc_arbiter with a small adder coprocessor model.
module tb_coproc_arbiter;
    localparam int unsigned MAT_W = 200;
    typedef logic [MAT_W:0] val_t;

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    coproc_arbiter_if #(.MAT_W(MAT_W)) bus ();

    coproc_arbiter #(.MAT_W(MAT_W), .TIMEOUT(15)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Coprocessor model: adds the operands; done rises mdl_delay cycles after start (<0: never).
    int   mdl_delay;
    int   mdl_cnt;
    logic mdl_done;
    logic stuck_done;
    always @(posedge clk) begin
        if (!bus.cp_start) begin
            mdl_cnt  <= 0;
            mdl_done <= 1'b0;
        end else if (mdl_delay >= 0 && mdl_cnt == mdl_delay) begin
            mdl_done <= 1'b1;
        end else begin
            mdl_cnt <= mdl_cnt + 1;
        end
    end
    assign bus.cp_done = mdl_done | stuck_done;
    assign {bus.cp_overflow, bus.cp_result} = {1'b0, bus.cp_m1} + {1'b0, bus.cp_m2};

    always @(negedge clk) begin
        total++;
        assert (!((|bus.gnt) && (|bus.rsp_valid))) else begin
            bad++;
            $error("FAIL gnt_rsp_excl: gnt=%b rsp_valid=%b, want not both", bus.gnt, bus.rsp_valid);
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "time limit");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input val_t obs, input val_t exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic wait_gnt(output logic [1:0] g);
        int n = 0;
        while (bus.gnt == 2'b00 && n < 50) begin
            tick();
            n++;
        end
        chk("gnt_seen", val_t'(bus.gnt != 2'b00), val_t'(1));
        g = bus.gnt;
    endtask

    task automatic wait_rsp();
        int n = 0;
        while (bus.rsp_valid == 2'b00 && n < 100) begin
            tick();
            n++;
        end
        chk("rsp_seen", val_t'(bus.rsp_valid != 2'b00), val_t'(1));
    endtask

    task automatic ack(input logic [1:0] a);
        bus.rsp_ack = a;
        tick();
        bus.rsp_ack = 2'b00;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_gnt"},   val_t'(bus.gnt), val_t'(0));
        chk({tag, "_rspv"},  val_t'(bus.rsp_valid), val_t'(0));
        chk({tag, "_res"},   val_t'(bus.result), val_t'(0));
        chk({tag, "_ovf"},   val_t'(bus.ovf), val_t'(0));
        chk({tag, "_to"},    val_t'(bus.timeout_err), val_t'(0));
        chk({tag, "_busy"},  val_t'(bus.busy), val_t'(0));
        chk({tag, "_start"}, val_t'(bus.cp_start), val_t'(0));
        chk({tag, "_op"},    val_t'(bus.cp_op), val_t'(0));
        chk({tag, "_m1"},    val_t'(bus.cp_m1), val_t'(0));
        chk({tag, "_m2"},    val_t'(bus.cp_m2), val_t'(0));
    endtask

    logic [1:0]       g;
    logic [1:0]       exp_g;
    logic [MAT_W-1:0] ramp;
    val_t             sum;
    int               n;

    initial begin
        reset = 1'b1;
        bus.req = 2'b00;
        bus.op0 = 3'd0;
        bus.op1 = 3'd0;
        bus.tam0 = 2'd0;
        bus.tam1 = 2'd0;
        bus.a0 = '0;
        bus.b0 = '0;
        bus.a1 = '0;
        bus.b1 = '0;
        bus.rsp_ack = 2'b00;
        mdl_delay = 5;
        stuck_done = 1'b0;
        for (int i = 0; i < 25; i++) ramp[8*i +: 8] = 8'(i);

        // Reset state
        tick();
        tick();
        chk_all_zero("rst");
        reset = 1'b0;

        // 1: single request on port 0, done 5 cycles after start
        bus.op0 = 3'b101;
        bus.tam0 = 2'b10;
        bus.a0 = ramp;
        bus.b0 = ramp;
        bus.req = 2'b01;
        tick();
        chk("t1_gnt", val_t'(bus.gnt), val_t'(2'b01));
        chk("t1_op", val_t'(bus.cp_op), val_t'(3'b101));
        chk("t1_tam", val_t'(bus.cp_tam), val_t'(2'b10));
        chk("t1_m1", val_t'(bus.cp_m1), val_t'(ramp));
        chk("t1_busy", val_t'(bus.busy), val_t'(1));
        chk("t1_start_drain", val_t'(bus.cp_start), val_t'(0));
        bus.req = 2'b00;
        tick();
        chk("t1_gnt_pulse", val_t'(bus.gnt), val_t'(0));
        chk("t1_start_run", val_t'(bus.cp_start), val_t'(1));
        wait_rsp();
        sum = {1'b0, ramp} + {1'b0, ramp};
        chk("t1_rspv", val_t'(bus.rsp_valid), val_t'(2'b01));
        chk("t1_result", val_t'(bus.result), val_t'(sum[MAT_W-1:0]));
        chk("t1_ovf", val_t'(bus.ovf), val_t'(0));
        chk("t1_to", val_t'(bus.timeout_err), val_t'(0));
        ack(2'b01);
        chk("t1_idle_rspv", val_t'(bus.rsp_valid), val_t'(0));
        chk("t1_idle_busy", val_t'(bus.busy), val_t'(0));
        chk("t1_idle_start", val_t'(bus.cp_start), val_t'(0));

        // 2: both requesting continuously -> 0,1,0,1
        reset = 1'b1;
        tick();
        reset = 1'b0;
        mdl_delay = 0;
        bus.req = 2'b11;
        for (int i = 0; i < 4; i++) begin
            exp_g = (i % 2 == 0) ? 2'b01 : 2'b10;
            wait_gnt(g);
            chk("t2_gnt", val_t'(g), val_t'(exp_g));
            if (i == 3) bus.req = 2'b00;
            wait_rsp();
            chk("t2_owner", val_t'(bus.rsp_valid), val_t'(exp_g));
            tick();
            ack(exp_g);
        end

        // 3: watchdog with TIMEOUT=15 on port 1
        mdl_delay = -1;
        bus.op1 = 3'b011;
        bus.a1 = ramp;
        bus.b1 = ~ramp;
        bus.req = 2'b10;
        wait_gnt(g);
        chk("t3_gnt", val_t'(g), val_t'(2'b10));
        bus.req = 2'b00;
        tick();
        chk("t3_start", val_t'(bus.cp_start), val_t'(1));
        n = 0;
        while (bus.rsp_valid == 2'b00 && n < 100) begin
            tick();
            n++;
        end
        chk("t3_run_cycles", val_t'(n), val_t'(16));
        chk("t3_rspv", val_t'(bus.rsp_valid), val_t'(2'b10));
        chk("t3_to", val_t'(bus.timeout_err), val_t'(1));
        chk("t3_result", val_t'(bus.result), val_t'(0));
        chk("t3_ovf", val_t'(bus.ovf), val_t'(0));
        ack(2'b01);
        chk("t3_wrong_ack", val_t'(bus.rsp_valid), val_t'(2'b10));
        ack(2'b10);
        chk("t3_idle_busy", val_t'(bus.busy), val_t'(0));
        chk("t3_idle_rspv", val_t'(bus.rsp_valid), val_t'(0));

        // 4: stale done held high through DRAIN
        mdl_delay = 2;
        stuck_done = 1'b1;
        bus.req = 2'b01;
        wait_gnt(g);
        chk("t4_gnt", val_t'(g), val_t'(2'b01));
        bus.req = 2'b00;
        for (int i = 0; i < 6; i++) begin
            chk("t4_start_low", val_t'(bus.cp_start), val_t'(0));
            tick();
        end
        stuck_done = 1'b0;
        chk("t4_start_still_low", val_t'(bus.cp_start), val_t'(0));
        tick();
        chk("t4_start_high", val_t'(bus.cp_start), val_t'(1));
        wait_rsp();
        chk("t4_owner", val_t'(bus.rsp_valid), val_t'(2'b01));
        ack(2'b01);

        // 5: reset pulse in the middle of RUN
        mdl_delay = -1;
        bus.req = 2'b10;
        wait_gnt(g);
        bus.req = 2'b00;
        tick();
        tick();
        tick();
        chk("t5_in_run", val_t'(bus.cp_start), val_t'(1));
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk_all_zero("t5_rst");
        mdl_delay = 1;
        bus.req = 2'b11;
        tick();
        chk("t5_first_gnt", val_t'(bus.gnt), val_t'(2'b01));
        bus.req = 2'b00;
        wait_rsp();
        ack(2'b01);

        // 6: slow ack with port 1 waiting; overflow result
        mdl_delay = 0;
        bus.a0 = '1;
        bus.b0 = MAT_W'(1);
        bus.req = 2'b01;
        wait_gnt(g);
        chk("t6_gnt", val_t'(g), val_t'(2'b01));
        bus.req = 2'b10;
        wait_rsp();
        chk("t6_rspv", val_t'(bus.rsp_valid), val_t'(2'b01));
        chk("t6_result", val_t'(bus.result), val_t'(0));
        chk("t6_ovf", val_t'(bus.ovf), val_t'(1));
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("t6_hold_rspv", val_t'(bus.rsp_valid), val_t'(2'b01));
            chk("t6_hold_res", val_t'(bus.result), val_t'(0));
            chk("t6_hold_ovf", val_t'(bus.ovf), val_t'(1));
            chk("t6_no_gnt", val_t'(bus.gnt), val_t'(0));
        end
        ack(2'b01);
        wait_gnt(g);
        chk("t6_next_gnt", val_t'(g), val_t'(2'b10));
        bus.req = 2'b00;
        wait_rsp();
        chk("t6_owner1", val_t'(bus.rsp_valid), val_t'(2'b10));
        ack(2'b10);
        chk("t6_end_busy", val_t'(bus.busy), val_t'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
